// File: rtl/word_framer_pkg.sv
// Shared encodings and byte classification for the word framer.
package word_framer_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TERM  = 2'd2
  } state_e;

  localparam logic [7:0] SP       = 8'h20;
  localparam logic [7:0] HT       = 8'h09;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] PRINT_LO = 8'h21;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  function automatic logic is_delim(input logic [7:0] b);
    return (b == SP) || (b == HT) || (b == LF) || (b == CR);
  endfunction

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/word_buffer.sv
// Word storage: DEPTH x 8 register array, one write port, combinational read.
module word_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  // NOTE: storage is deliberately not reset; len in the parent defines which
  // entries are meaningful, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Guard keeps non-power-of-two depths from reading past the array.
  assign rdata = ({1'b0, raddr} < (AW + 1)'(DEPTH)) ? mem_q[raddr] : 8'h00;

endmodule

// File: rtl/word_framer.sv
// Buffers each word until its delimiter, then replays it at one char per
// clock followed by a single space, back-pressuring the host meanwhile.
module word_framer
  import word_framer_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] IDLE_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic [7:0] out_char,
  output logic       out_valid,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    out_char_q, out_char_d;
  logic          out_valid_q, out_valid_d;
  logic          overflow_q, overflow_d;

  logic          buf_we;
  logic [7:0]    buf_rdata;

  word_buffer #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (len_q[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (buf_rdata)
  );

  assign in_ready = (state_q == ST_FILL) && !flush;

  // NOTE: every signal gets its default before the case so that no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    out_char_d  = IDLE_CHAR;
    out_valid_d = 1'b0;
    buf_we      = 1'b0;

    unique case (state_q)
      ST_FILL: begin
        if (flush) begin
          if (len_q != '0) begin
            state_d  = ST_DRAIN;
            rd_ptr_d = '0;
          end
        end else if (in_valid) begin
          if (is_delim(in_data)) begin
            if (len_q != '0) begin
              state_d  = ST_DRAIN;
              rd_ptr_d = '0;
            end
          end else if (is_printable(in_data)) begin
            if (len_q < LW'(DEPTH)) begin
              buf_we = 1'b1;
              len_d  = len_q + LW'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end
        end
      end

      ST_DRAIN: begin
        out_char_d  = buf_rdata;
        out_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + AW'(1);
        if (LW'(rd_ptr_q) == len_q - LW'(1)) state_d = ST_TERM;
      end

      ST_TERM: begin
        out_char_d  = SP;
        out_valid_d = 1'b1;
        len_d       = '0;
        state_d     = ST_FILL;
      end

      default: state_d = ST_FILL;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FILL;
      len_q       <= '0;
      rd_ptr_q    <= '0;
      out_char_q  <= IDLE_CHAR;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rd_ptr_q    <= rd_ptr_d;
      out_char_q  <= out_char_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_char  = out_char_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

endmodule
